// File: rtl/sseg_mux_pwm_n.sv
// Multiplexed seven-segment driver for NUM_DIGITS common-anode digits.
// Scans one digit per slot of 2^REFRESH_BITS cycles. Each digit gets hex
// decode, a decimal point, blanking, and optional leading-zero suppression.
// Brightness is set by PWM, and the duty code is latched once per frame.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous reset, active-low
//   hex_in      digit i nibble at [4i+3:4i]; digit 0 is the rightmost digit
//   dp_in       decimal point request per digit, active-high
//   blank       force a digit dark, active-high
//   lz_en       enable leading-zero suppression
//   brightness  PWM duty code (all-ones means always lit)
//   an          anode enables, active-low, at most one low at a time
//   sseg        segments, active-low, {dp, g, f, e, d, c, b, a}
//   frame_tick  one-cycle pulse after each full scan
module sseg_mux_pwm_n #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_BITS = 18,
  parameter int unsigned PWM_RES      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  input  logic [PWM_RES-1:0]      brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic                    frame_tick
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [REFRESH_BITS-1:0] cnt;
  logic [IDX_W-1:0]        idx;
  logic [PWM_RES-1:0]      duty_q;
  logic [3:0]              hex_q;
  logic                    dp_q;
  logic                    blank_q;

  logic                    slot_end;
  logic                    frame_end;
  logic [IDX_W-1:0]        next_idx;
  logic [NUM_DIGITS-1:0]   supp;
  logic                    zero_run;
  logic [PWM_RES-1:0]      phase;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [7:0]              sseg_d;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot and frame boundaries, and the digit that the next slot will show.
  always_comb begin
    slot_end  = &cnt;
    frame_end = slot_end && (idx == LAST_IDX);
    next_idx  = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  end

  // A digit is a leading zero if it and every digit above it are zero with
  // no decimal point. Digit 0 is always shown.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (hex_in[4*i +: 4] == 4'h0) && !dp_in[i];
      supp[i]  = lz_en && zero_run && (i != 0);
    end
  end

  // PWM compare against the low bits of the slot counter.
  always_comb begin
    phase = cnt[PWM_RES-1:0];
    lit   = (&duty_q) || (phase < duty_q);
  end

  // Next pin values. Only the current digit's anode can go low.
  always_comb begin
    an_d   = '1;
    sseg_d = 8'hFF;
    if (!blank_q) begin
      sseg_d = {~dp_q, seg_decode(hex_q)};
      if (lit) begin
        an_d[idx] = 1'b0;
      end
    end
  end

  // Scan counters and per-frame brightness latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      idx    <= '0;
      duty_q <= '1;
    end else begin
      cnt <= cnt + REFRESH_BITS'(1);
      if (slot_end) begin
        idx <= next_idx;
      end
      if (frame_end) begin
        duty_q <= brightness;
      end
    end
  end

  // Capture the next digit's data at the slot boundary, so that input
  // changes never disturb the slot that is being shown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_q   <= 4'h0;
      dp_q    <= 1'b0;
      blank_q <= 1'b1;
    end else if (slot_end) begin
      hex_q   <= hex_in[{next_idx, 2'b00} +: 4];
      dp_q    <= dp_in[next_idx];
      blank_q <= blank[next_idx] | supp[next_idx];
    end
  end

  // Registered pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an         <= '1;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_d;
      sseg       <= sseg_d;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_sseg_mux_pwm_n.sv
// Directed testbench for sseg_mux_pwm_n with 4 digits, 64-cycle slots and
// 16-step PWM. The variable t counts rising edges since reset release. The
// pins after edge t show scan state s = t-1, where digit = (s/64)%4,
// phase = s%16 and frame = s/256.
module tb_sseg_mux_pwm_n;

  logic        clk;
  logic        reset;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        lz_en;
  logic [3:0]  brightness;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;

  int vectors    = 0;
  int miscompares = 0;
  int t = 0;

  sseg_mux_pwm_n #(
    .NUM_DIGITS  (4),
    .REFRESH_BITS(6),
    .PWM_RES     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hex_in    (hex_in),
    .dp_in     (dp_in),
    .blank     (blank),
    .lz_en     (lz_en),
    .brightness(brightness),
    .an        (an),
    .sseg      (sseg),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to edge count target, then sample 1 ns after the edge.
  task automatic go_to(input int target);
    while (t < target) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      hex_in     = 16'($urandom);
      dp_in      = 4'($urandom);
      blank      = 4'($urandom);
      lz_en      = 1'($urandom);
      brightness = 4'($urandom);
      @(negedge clk);
      vectors++;
      if (an !== 4'hF) begin
        miscompares++;
        $display("FAIL reset_an[%0d]: got %b expected 1111", k, an);
      end
      vectors++;
      if (sseg !== 8'hFF) begin
        miscompares++;
        $display("FAIL reset_sseg[%0d]: got %h expected ff", k, sseg);
      end
      vectors++;
      if (frame_tick !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_frame_tick[%0d]: got %b expected 0", k, frame_tick);
      end
    end
    hex_in     = 16'h3210;
    dp_in      = 4'b0000;
    blank      = 4'b0000;
    lz_en      = 1'b0;
    brightness = 4'hF;
    @(posedge clk);
    #2;
    reset = 1'b1;
    t = 0;
  endtask

  task automatic test_scan;
    logic [7:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg[0] = 8'hC0; exp_seg[1] = 8'hF9; exp_seg[2] = 8'hA4; exp_seg[3] = 8'hB0;
    // Digit 0 is dark in the first slot; captured data starts at digit 1.
    go_to(11);
    vectors++;
    if (an !== 4'hF || sseg !== 8'hFF) begin
      miscompares++;
      $display("FAIL first_slot_dark: got an=%b sseg=%h expected an=1111 sseg=ff", an, sseg);
    end
    go_to(70);
    vectors++;
    if (an !== 4'b1101 || sseg !== 8'hF9) begin
      miscompares++;
      $display("FAIL first_digit1: got an=%b sseg=%h expected an=1101 sseg=f9", an, sseg);
    end
    go_to(255);
    vectors++;
    if (frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_tick_pre: got %b expected 0", frame_tick);
    end
    go_to(256);
    vectors++;
    if (frame_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_tick_256: got %b expected 1", frame_tick);
    end
    go_to(257);
    vectors++;
    if (frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_tick_post: got %b expected 0", frame_tick);
    end
    // Frame 1: each digit lit at slot start and still lit at slot end.
    for (int d = 0; d < 4; d++) begin
      exp_an = ~(4'b0001 << d);
      go_to(256 + 64*d + 6);
      vectors++;
      if (an !== exp_an || sseg !== exp_seg[d]) begin
        miscompares++;
        $display("FAIL scan_start d%0d: got an=%b sseg=%h expected an=%b sseg=%h",
                 d, an, sseg, exp_an, exp_seg[d]);
      end
      go_to(256 + 64*d + 64);
      vectors++;
      if (an !== exp_an || sseg !== exp_seg[d]) begin
        miscompares++;
        $display("FAIL scan_end d%0d: got an=%b sseg=%h expected an=%b sseg=%h",
                 d, an, sseg, exp_an, exp_seg[d]);
      end
    end
    vectors++;
    if (frame_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_tick_512: got %b expected 1", frame_tick);
    end
  endtask

  task automatic test_pwm;
    int lows;
    int stray;
    // A mid-frame change in frame 2 must not apply until frame 3.
    go_to(521);
    brightness = 4'h4;
    go_to(601);
    vectors++;
    if (an !== 4'b1101) begin
      miscompares++;
      $display("FAIL pwm_midframe_hold: got %b expected 1101", an);
    end
    // Frame 3, digit 1: lit on phases 0..3 only, which is 16 of 64 cycles.
    lows  = 0;
    stray = 0;
    for (int k = 833; k <= 896; k++) begin
      go_to(k);
      if (an[1] === 1'b0) lows++;
      if (an[3] !== 1'b1 || an[2] !== 1'b1 || an[0] !== 1'b1) stray++;
    end
    vectors++;
    if (lows !== 16) begin
      miscompares++;
      $display("FAIL pwm_duty4_count: got %0d expected 16", lows);
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL pwm_other_anodes: got %0d expected 0", stray);
    end
    go_to(897);
    vectors++;
    if (an !== 4'b1011) begin
      miscompares++;
      $display("FAIL pwm_phase0: got %b expected 1011", an);
    end
    go_to(900);
    vectors++;
    if (an !== 4'b1011) begin
      miscompares++;
      $display("FAIL pwm_phase3: got %b expected 1011", an);
    end
    go_to(901);
    vectors++;
    if (an !== 4'hF) begin
      miscompares++;
      $display("FAIL pwm_phase4: got %b expected 1111", an);
    end
    go_to(912);
    vectors++;
    if (an !== 4'hF) begin
      miscompares++;
      $display("FAIL pwm_phase15: got %b expected 1111", an);
    end
    // Brightness 0 set in frame 3 keeps frame 4 fully dark.
    go_to(921);
    brightness = 4'h0;
    stray = 0;
    for (int k = 1025; k <= 1200; k++) begin
      go_to(k);
      if (an !== 4'hF) stray++;
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL pwm_zero_dark: got %0d lit cycles expected 0", stray);
    end
  endtask

  task automatic test_leading_zero;
    go_to(1201);
    brightness = 4'hF;
    lz_en      = 1'b1;
    hex_in     = 16'h0050;
    go_to(1286);
    vectors++;
    if (an !== 4'b1110 || sseg !== 8'hC0) begin
      miscompares++;
      $display("FAIL lz_0050_d0: got an=%b sseg=%h expected an=1110 sseg=c0", an, sseg);
    end
    go_to(1350);
    vectors++;
    if (an !== 4'b1101 || sseg !== 8'h92) begin
      miscompares++;
      $display("FAIL lz_0050_d1: got an=%b sseg=%h expected an=1101 sseg=92", an, sseg);
    end
    go_to(1414);
    vectors++;
    if (an !== 4'hF || sseg !== 8'hFF) begin
      miscompares++;
      $display("FAIL lz_0050_d2: got an=%b sseg=%h expected an=1111 sseg=ff", an, sseg);
    end
    go_to(1478);
    vectors++;
    if (an !== 4'hF || sseg !== 8'hFF) begin
      miscompares++;
      $display("FAIL lz_0050_d3: got an=%b sseg=%h expected an=1111 sseg=ff", an, sseg);
    end
    go_to(1480);
    hex_in = 16'h0000;
    go_to(1542);
    vectors++;
    if (an !== 4'b1110 || sseg !== 8'hC0) begin
      miscompares++;
      $display("FAIL lz_0000_d0: got an=%b sseg=%h expected an=1110 sseg=c0", an, sseg);
    end
    go_to(1606);
    vectors++;
    if (an !== 4'hF || sseg !== 8'hFF) begin
      miscompares++;
      $display("FAIL lz_0000_d1: got an=%b sseg=%h expected an=1111 sseg=ff", an, sseg);
    end
    go_to(1734);
    vectors++;
    if (an !== 4'hF || sseg !== 8'hFF) begin
      miscompares++;
      $display("FAIL lz_0000_d3: got an=%b sseg=%h expected an=1111 sseg=ff", an, sseg);
    end
    // A decimal point on the top digit stops all suppression.
    go_to(1740);
    dp_in = 4'b1000;
    go_to(1862);
    vectors++;
    if (an !== 4'b1101 || sseg !== 8'hC0) begin
      miscompares++;
      $display("FAIL lz_dp3_d1: got an=%b sseg=%h expected an=1101 sseg=c0", an, sseg);
    end
    go_to(1926);
    vectors++;
    if (an !== 4'b1011 || sseg !== 8'hC0) begin
      miscompares++;
      $display("FAIL lz_dp3_d2: got an=%b sseg=%h expected an=1011 sseg=c0", an, sseg);
    end
    go_to(1990);
    vectors++;
    if (an !== 4'b0111 || sseg !== 8'h40) begin
      miscompares++;
      $display("FAIL lz_dp3_d3: got an=%b sseg=%h expected an=0111 sseg=40", an, sseg);
    end
  endtask

  task automatic test_blank_dp;
    int bad;
    go_to(2000);
    lz_en  = 1'b0;
    dp_in  = 4'b0001;
    hex_in = 16'h0008;
    blank  = 4'b0100;
    go_to(2054);
    vectors++;
    if (an !== 4'b1110 || sseg !== 8'h00) begin
      miscompares++;
      $display("FAIL dp_d0_8: got an=%b sseg=%h expected an=1110 sseg=00", an, sseg);
    end
    go_to(2123);
    vectors++;
    if (an !== 4'b1101 || sseg !== 8'hC0) begin
      miscompares++;
      $display("FAIL blank_d1: got an=%b sseg=%h expected an=1101 sseg=c0", an, sseg);
    end
    // Digit 2 stays dark for its whole slot, even after the inputs change
    // mid-slot. The change shows up first in digit 3's slot.
    bad = 0;
    for (int k = 2177; k <= 2240; k++) begin
      go_to(k);
      if (k == 2210) begin
        hex_in = 16'hBA98;
        blank  = 4'b0000;
      end
      if (an !== 4'hF || sseg !== 8'hFF) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL blank_d2_dark: got %0d bad cycles expected 0", bad);
    end
    go_to(2246);
    vectors++;
    if (an !== 4'b0111 || sseg !== 8'h83) begin
      miscompares++;
      $display("FAIL midslot_next_d3: got an=%b sseg=%h expected an=0111 sseg=83", an, sseg);
    end
    go_to(2438);
    vectors++;
    if (an !== 4'b1011 || sseg !== 8'h88) begin
      miscompares++;
      $display("FAIL unblank_d2: got an=%b sseg=%h expected an=1011 sseg=88", an, sseg);
    end
  endtask

  task automatic test_reset_midscan;
    go_to(2450);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (an !== 4'hF || sseg !== 8'hFF || frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got an=%b sseg=%h ft=%b expected an=1111 sseg=ff ft=0",
               an, sseg, frame_tick);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (an !== 4'hF || sseg !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_held: got an=%b sseg=%h expected an=1111 sseg=ff", an, sseg);
    end
    hex_in     = 16'h3210;
    dp_in      = 4'b0000;
    blank      = 4'b0000;
    lz_en      = 1'b0;
    brightness = 4'hF;
    @(posedge clk);
    #2;
    reset = 1'b1;
    t = 0;
    go_to(10);
    vectors++;
    if (an !== 4'hF || sseg !== 8'hFF) begin
      miscompares++;
      $display("FAIL restart_dark: got an=%b sseg=%h expected an=1111 sseg=ff", an, sseg);
    end
    go_to(70);
    vectors++;
    if (an !== 4'b1101 || sseg !== 8'hF9) begin
      miscompares++;
      $display("FAIL restart_d1: got an=%b sseg=%h expected an=1101 sseg=f9", an, sseg);
    end
    go_to(134);
    vectors++;
    if (an !== 4'b1011 || sseg !== 8'hA4) begin
      miscompares++;
      $display("FAIL restart_d2: got an=%b sseg=%h expected an=1011 sseg=a4", an, sseg);
    end
    go_to(256);
    vectors++;
    if (frame_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_frame_tick: got %b expected 1", frame_tick);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_pwm();
    test_leading_zero();
    test_blank_dp();
    test_reset_midscan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sseg_mux_pwm_n.md
# sseg_mux_pwm_n

Parametrised multiplexed seven-segment display driver for N common-anode digits. It has per-digit hex decode, decimal points, blanking, optional leading-zero suppression and frame-synchronous PWM brightness. It replaces the fixed 4-digit multiplexer at board top level. It drives the active-low anode and segment pins directly from registered outputs.

## Interface

- NUM_DIGITS, 8, number of digits scanned (2..16)
- REFRESH_BITS, 18, width of per-slot counter; slot length = 2^REFRESH_BITS cycles; must be ≥ PWM_RES+1
- PWM_RES, 4, brightness resolution in bits
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- hex_in  in  4*NUM_DIGITS  digit i nibble at [4i+3:4i]; digit 0 is rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high
- blank  in  NUM_DIGITS  force digit dark, active-high
- lz_en  in  1  enable leading-zero suppression
- brightness  in  PWM_RES  duty code
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all-high
- sseg  out  8  segments, active-low; [0]=a … [6]=g, [7]=dp
- frame_tick  out  1  one-cycle pulse at end of each full scan

## Operation

- State: slot counter cnt[REFRESH_BITS-1:0] increments every cycle. Digit index idx advances 0→1→…→NUM_DIGITS-1→0 on the edge where cnt wraps from all-ones to 0.
- Slot boundary = the edge where cnt wraps. On that edge, the next digit's nibble, dp, blank and suppression flag are captured into slot registers. Inputs may change freely and affect only later slots.
- Frame boundary = slot boundary where idx wraps NUM_DIGITS-1→0. brightness is latched into duty_q here only. frame_tick=1 for the cycle after this edge.
- Leading-zero suppression: evaluated from live inputs at each slot boundary. With lz_en=1, digit i is suppressed if every digit j ≥ i has nibble 0 and dp_in[j]=0 and i ≠ 0. Digit 0 is never suppressed. Suppressed digits are treated as blanked.
- PWM: phase = cnt[PWM_RES-1:0]. Lit when duty_q = all-ones, or when phase < duty_q. duty_q = 0 means never lit.
- Output next-state:
  - For an, only bit idx may be 0. It is 0 iff the digit is not blanked/suppressed and PWM is lit.
  - sseg is 8'hFF when blanked/suppressed. Otherwise it is {~dp, decoded gfedcba}.
- Decode, as the sseg byte with dp off: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.

## Timing

- Reset (reset=0, asynchronous):
  - cnt=0, idx=0, duty_q=all-ones.
  - Slot registers hold hex 0, dp 0, blank 1.
  - an=all-ones, sseg=8'hFF, frame_tick=0.
- After release, display is dark for the first slot of digit 0 (2^REFRESH_BITS cycles). The first captured data appears at digit 1.
- an and sseg are registered: one cycle latency from the cnt/idx values to the pins.
- an and sseg change together on the same edge. There are never two anodes low.
- Reset asserted mid-scan forces outputs dark immediately, without waiting for a clock edge. The scan restarts at idx=0 after release.
- brightness changes mid-frame take effect only after the next frame boundary.
- Simultaneous slot and frame boundary: the brightness latch and digit capture occur on the same edge.

## Test plan

Bench parameters: NUM_DIGITS=4, REFRESH_BITS=6, PWM_RES=4.

1. Reset behaviour:
   - Hold reset=0 with random inputs -> an=4'hF, sseg=8'hFF, frame_tick=0.
   - Assert reset mid-slot -> outputs go dark asynchronously, and the scan restarts at digit 0.
2. Scan and decode:
   - hex_in=16'h3210, brightness=4'hF, blank=0, lz_en=0 -> an steps 1110, 1101, 1011, 0111, each held 64 cycles.
   - sseg shows C0, F9, A4, B0 for those digits.
   - frame_tick pulses every 256 cycles.
3. PWM:
   - brightness=4'h4 -> each digit's anode is low 4 of every 16 cycles (phases 0–3).
   - brightness=0 -> an stays all-high.
   - Changing brightness mid-frame takes effect only at the next frame boundary.
4. Leading zeros:
   - lz_en=1, hex_in=16'h0050 -> digits 3 and 2 are dark; digit 1 shows 92; digit 0 shows C0.
   - hex_in=16'h0000 -> only digit 0 lit, showing C0.
   - dp_in=4'b1000 with hex_in=16'h0000 -> digit 3 shows 40, and no digit is suppressed.
5. Blank and dp:
   - blank=4'b0100 -> digit 2's anode never goes low, and sseg=FF during its slot.
   - dp_in=4'b0001, hex_in[3:0]=8 -> digit 0 shows 00.
   - Inputs changed mid-slot alter only the next slot's output.
